// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game: button codes, colour encodings and KEY bit positions.
// Used by both the button decoder and the game controller.
package genius_pkg;

   localparam int NUM_KEYS = 5;

   localparam int KEY_POWER  = 0;
   localparam int KEY_GREEN  = 1;
   localparam int KEY_RED    = 2;
   localparam int KEY_BLUE   = 3;
   localparam int KEY_YELLOW = 4;

   localparam logic [2:0] BTN_NONE   = 3'd0;
   localparam logic [2:0] BTN_POWER  = 3'd1;
   localparam logic [2:0] BTN_GREEN  = 3'd2;
   localparam logic [2:0] BTN_RED    = 3'd3;
   localparam logic [2:0] BTN_BLUE   = 3'd4;
   localparam logic [2:0] BTN_YELLOW = 3'd6;

   typedef enum logic [1:0] {
      COLOR_BLUE   = 2'b00,
      COLOR_GREEN  = 2'b01,
      COLOR_RED    = 2'b10,
      COLOR_YELLOW = 2'b11
   } color_t;

   // Maps a one-hot stable key vector to its button code; anything else is NONE.
   function automatic logic [2:0] button_code(input logic [NUM_KEYS-1:0] keys);
      logic [2:0] code;
      code = BTN_NONE;
      case (keys)
         5'b00001: code = BTN_POWER;
         5'b00010: code = BTN_GREEN;
         5'b00100: code = BTN_RED;
         5'b01000: code = BTN_BLUE;
         5'b10000: code = BTN_YELLOW;
         default:  code = BTN_NONE;
      endcase
      return code;
   endfunction

   function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] keys);
      return (keys != '0) && ((keys & (keys - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/genius_debounce.sv
// One-key conditioner: 2-flop synchronizer followed by a stable-level debouncer.
// The stable bit only toggles after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module genius_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic key_raw,
   output logic level,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          meta;
   logic [CW-1:0] count;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         meta   <= 1'b0;
         level  <= 1'b0;
         stable <= 1'b0;
         count  <= '0;
      end else begin
         meta  <= key_raw;
         level <= meta;
         if (level == stable) begin
            count <= '0;
         end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= ~stable;
            count  <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/genius_button_decoder.sv
// Button front-end for the Genius controller: debounces five keys into one R pulse per press
// with a held code B, and runs the free-running LFSR that supplies the random colour C.
module genius_button_decoder
   import genius_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter bit          KEY_ACTIVE_LOW  = 1'b1,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [4:0] KEY,
   output logic       R,
   output logic [2:0] B,
   output logic [1:0] C,
   output logic       KEY_HELD
);

   typedef enum logic {IDLE, HELD} state_t;

   logic [NUM_KEYS-1:0] key_cond;
   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] stable;
   logic [1:0]          sync_fill;
   logic                release_ok;
   state_t              state;
   state_t              state_next;
   logic                r_next;
   logic [2:0]          b_next;
   logic [15:0]         lfsr;
   logic                feedback;

   assign key_cond = KEY_ACTIVE_LOW ? ~KEY : KEY;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      genius_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .CLK    (CLK),
         .RESET  (RESET),
         .key_raw(key_cond[i]),
         .level  (level[i]),
         .stable (stable[i])
      );
   end

   // Release is only trusted once the synchronizers have refilled after reset, so a key
   // held across reset is seen as down and must be released before it can fire.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_fill <= 2'b00;
      end else begin
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   assign release_ok = sync_fill[1] && (stable == '0) && (level == '0);

   // Reset lands in HELD, which is what forces the release-before-repress rule after reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= HELD;
         R     <= 1'b0;
         B     <= BTN_NONE;
      end else begin
         state <= state_next;
         R     <= r_next;
         B     <= b_next;
      end
   end

   always_comb begin
      state_next = state;
      r_next     = 1'b0;
      b_next     = B;
      case (state)
         IDLE: begin
            if (stable != '0) begin
               state_next = HELD;
               if (is_one_hot(stable)) begin
                  r_next = 1'b1;
                  b_next = button_code(stable);
               end
            end
         end
         HELD: begin
            if (release_ok) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign KEY_HELD = (state == HELD) && (stable != '0);

   assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], feedback};
      end
   end

   assign C = lfsr[1:0];

endmodule

// File: tb/tb_genius_button_decoder.sv
// Directed self-checking bench for genius_button_decoder with DEBOUNCE_CYCLES=4, active-low keys.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_genius_button_decoder;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [4:0] KEY;
   logic       R;
   logic [2:0] B;
   logic [1:0] C;
   logic       KEY_HELD;

   int errors = 0;
   int checks = 0;

   genius_button_decoder #(
      .DEBOUNCE_CYCLES(4),
      .KEY_ACTIVE_LOW (1'b1),
      .LFSR_SEED      (16'hACE1)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .KEY     (KEY),
      .R       (R),
      .B       (B),
      .C       (C),
      .KEY_HELD(KEY_HELD)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      KEY   = 5'b11111;
      repeat (3) tick();
      checks++; if (R !== 1'b0) begin errors++; $display("[TB] FAIL reset_r: got %b expected 0", R); end
      checks++; if (B !== 3'd0) begin errors++; $display("[TB] FAIL reset_b: got %0d expected 0", B); end
      checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("[TB] FAIL reset_held: got %b expected 0", KEY_HELD); end
      checks++; if (C !== 2'b01) begin errors++; $display("[TB] FAIL reset_c: got %b expected 01", C); end
      RESET = 1'b0;
      tick();
      checks++; if (C !== 2'b11) begin errors++; $display("[TB] FAIL lfsr_first_step: got %b expected 11", C); end
      repeat (5) tick();
   endtask

   task automatic test_single_press();
      KEY[1] = 1'b0;
      for (int e = 0; e <= 8; e++) begin
         tick();
         checks++;
         if (R !== (e == 6)) begin errors++; $display("[TB] FAIL green_r_edge%0d: got %b expected %b", e, R, (e == 6)); end
         if (e == 6) begin
            checks++; if (B !== 3'd2) begin errors++; $display("[TB] FAIL green_b_with_r: got %0d expected 2", B); end
            checks++; if (KEY_HELD !== 1'b1) begin errors++; $display("[TB] FAIL green_held: got %b expected 1", KEY_HELD); end
         end
      end
      KEY = 5'b11111;
      for (int e = 0; e <= 7; e++) begin
         tick();
         if (e == 4) begin
            checks++; if (KEY_HELD !== 1'b1) begin errors++; $display("[TB] FAIL green_release_early: got %b expected 1", KEY_HELD); end
         end
         if (e == 5) begin
            checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("[TB] FAIL green_release: got %b expected 0", KEY_HELD); end
         end
      end
      checks++; if (B !== 3'd2) begin errors++; $display("[TB] FAIL green_b_hold: got %0d expected 2", B); end
      repeat (3) tick();
   endtask

   task automatic test_glitch();
      int pulses = 0;
      int held   = 0;
      KEY[3] = 1'b0;
      repeat (3) begin tick(); if (R === 1'b1) pulses++; end
      KEY = 5'b11111;
      repeat (12) begin
         tick();
         if (R === 1'b1) pulses++;
         if (KEY_HELD !== 1'b0) held++;
      end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL glitch_r: got %0d pulses expected 0", pulses); end
      checks++; if (held != 0) begin errors++; $display("[TB] FAIL glitch_held: got %0d cycles expected 0", held); end
      checks++; if (B !== 3'd2) begin errors++; $display("[TB] FAIL glitch_b: got %0d expected 2", B); end
   endtask

   task automatic test_chord();
      int pulses = 0;
      int not_held = 0;
      KEY[2] = 1'b0;
      KEY[4] = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         if (R === 1'b1) pulses++;
         if (e >= 6 && KEY_HELD !== 1'b1) not_held++;
      end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL chord_r: got %0d pulses expected 0", pulses); end
      checks++; if (not_held != 0) begin errors++; $display("[TB] FAIL chord_held: got %0d low cycles expected 0", not_held); end
      KEY = 5'b11111;
      repeat (10) begin tick(); if (R === 1'b1) pulses++; end
      checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("[TB] FAIL chord_release: got %b expected 0", KEY_HELD); end
      checks++; if (B !== 3'd2) begin errors++; $display("[TB] FAIL chord_b: got %0d expected 2", B); end
      KEY[4] = 1'b0;
      for (int e = 0; e <= 8; e++) begin
         tick();
         if (R === 1'b1) pulses++;
         if (e == 6) begin
            checks++; if (R !== 1'b1) begin errors++; $display("[TB] FAIL yellow_r: got %b expected 1", R); end
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL yellow_pulses: got %0d expected 1", pulses); end
      checks++; if (B !== 3'd6) begin errors++; $display("[TB] FAIL yellow_b: got %0d expected 6", B); end
      KEY = 5'b11111;
      repeat (10) tick();
   endtask

   task automatic test_extra_key();
      int pulses = 0;
      KEY[0] = 1'b0;
      repeat (9) begin tick(); if (R === 1'b1) pulses++; end
      KEY[3] = 1'b0;
      repeat (15) begin tick(); if (R === 1'b1) pulses++; end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL power_pulses: got %0d expected 1", pulses); end
      checks++; if (B !== 3'd1) begin errors++; $display("[TB] FAIL power_b: got %0d expected 1", B); end
      checks++; if (KEY_HELD !== 1'b1) begin errors++; $display("[TB] FAIL power_held: got %b expected 1", KEY_HELD); end
      KEY = 5'b11111;
      repeat (10) tick();
      checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("[TB] FAIL power_release: got %b expected 0", KEY_HELD); end
      pulses = 0;
      KEY[3] = 1'b0;
      for (int e = 0; e <= 8; e++) begin
         tick();
         if (R === 1'b1) pulses++;
         if (e == 6) begin
            checks++; if (R !== 1'b1) begin errors++; $display("[TB] FAIL blue_r: got %b expected 1", R); end
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL blue_pulses: got %0d expected 1", pulses); end
      checks++; if (B !== 3'd4) begin errors++; $display("[TB] FAIL blue_b: got %0d expected 4", B); end
      KEY = 5'b11111;
      repeat (10) tick();
   endtask

   task automatic test_reset_mid_press();
      int pulses = 0;
      KEY[1] = 1'b0;
      repeat (9) begin tick(); if (R === 1'b1) pulses++; end
      checks++; if (pulses != 1 || B !== 3'd2) begin errors++; $display("[TB] FAIL prereset_press: got %0d pulses b=%0d expected 1 pulse b=2", pulses, B); end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      checks++; if (B !== 3'd0) begin errors++; $display("[TB] FAIL midreset_b: got %0d expected 0", B); end
      checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("[TB] FAIL midreset_held: got %b expected 0", KEY_HELD); end
      checks++; if (C !== 2'b01) begin errors++; $display("[TB] FAIL midreset_c: got %b expected 01", C); end
      pulses = 0;
      repeat (20) begin tick(); if (R === 1'b1) pulses++; end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL held_through_reset_r: got %0d pulses expected 0", pulses); end
      checks++; if (B !== 3'd0) begin errors++; $display("[TB] FAIL held_through_reset_b: got %0d expected 0", B); end
      KEY = 5'b11111;
      repeat (10) tick();
      KEY[1] = 1'b0;
      for (int e = 0; e <= 8; e++) begin
         tick();
         if (R === 1'b1) pulses++;
         if (e == 6) begin
            checks++; if (R !== 1'b1) begin errors++; $display("[TB] FAIL repress_r: got %b expected 1", R); end
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL repress_pulses: got %0d expected 1", pulses); end
      checks++; if (B !== 3'd2) begin errors++; $display("[TB] FAIL repress_b: got %0d expected 2", B); end
      KEY = 5'b11111;
      repeat (10) tick();
   endtask

   initial begin
      RESET = 1'b1;
      KEY   = 5'b11111;
      test_reset();
      test_single_press();
      test_glitch();
      test_chord();
      test_extra_key();
      test_reset_mid_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
